// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 instead of 8N1).
module uart_tx_fifo #(
   parameter int DEPTH_LOG2  = 4,
   parameter int DEFAULT_DIV = 106
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_div_we,
   input  logic [31:0]           cfg_div_di,
   output logic [31:0]           cfg_div_do,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic                  tx,
   output logic                  busy,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level_q;
   logic [31:0]           div_q;

   state_t      state_q, state_n;
   logic [7:0]  sh_q, sh_n;
   logic [2:0]  idx_q, idx_n;
   logic [31:0] cnt_q, cnt_n;
   logic [31:0] bdiv_q, bdiv_n;
   logic        tx_q, tx_n;
   logic        push, pop, bit_end;

   assign push    = in_valid && in_ready;
   assign bit_end = (cnt_q == bdiv_q - 32'd1);

   assign in_ready   = (level_q != FULL);
   assign busy       = (state_q != S_IDLE) || (level_q != '0);
   assign level      = level_q;
   assign tx         = tx_q;
   assign cfg_div_do = div_q;

   // tx is registered: tx_n is the line value for the state being entered
   always_comb begin
      state_n = state_q;
      sh_n    = sh_q;
      idx_n   = idx_q;
      cnt_n   = cnt_q + 32'd1;
      bdiv_n  = bdiv_q;
      tx_n    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_n = '0;
            tx_n  = 1'b1;
            if (level_q != '0) begin
               pop     = 1'b1;
               sh_n    = mem[rd_ptr];
               bdiv_n  = div_q;
               state_n = S_START;
               tx_n    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = S_DATA;
               tx_n    = sh_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_n = '0;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = S_PARITY;
                  tx_n    = ^sh_q;
`else
                  state_n = S_STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  idx_n = idx_q + 3'd1;
                  tx_n  = sh_q[idx_q + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = S_STOP;
               tx_n    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_n = '0;
               // chain straight into the next start bit when data waits
               if (level_q != '0) begin
                  pop     = 1'b1;
                  sh_n    = mem[rd_ptr];
                  bdiv_n  = div_q;
                  state_n = S_START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = S_IDLE;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = S_IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         bdiv_q  <= 32'(DEFAULT_DIV);
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_n;
         sh_q    <= sh_n;
         idx_q   <= idx_n;
         cnt_q   <= cnt_n;
         bdiv_q  <= bdiv_n;
         tx_q    <= tx_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= 32'(DEFAULT_DIV);
      end else if (cfg_div_we) begin
         div_q <= (cfg_div_di < 32'd2) ? 32'd2 : cfg_div_di;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single frame, fill/backpressure,
// divider change, reset mid-frame and (with UART_TX_PARITY_EN) parity frames.
module tb_uart_tx_fifo;

   localparam int DIV = 106;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_div_we = 1'b0;
   logic [31:0] cfg_div_di = '0;
   logic [31:0] cfg_div_do;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        tx;
   logic        busy;
   logic [4:0]  level;

   int vec = 0;
   int err = 0;
   int cyc = 0;

   uart_tx_fifo #(.DEPTH_LOG2(4), .DEFAULT_DIV(DIV)) dut (
      .clk(clk), .reset(reset),
      .cfg_div_we(cfg_div_we), .cfg_div_di(cfg_div_di),
      .cfg_div_do(cfg_div_do),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .tx(tx), .busy(busy), .level(level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   // frame bits in line order: bit0 = start, then data LSB first, then stop
   function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {2'b01, d, 1'b0};
`endif
   endfunction

   // call at a negedge; returns with acc = index of accepting posedge
   task automatic push(input logic [7:0] d, output int acc, output bit to);
      int n;
      logic rdy;
      n = 0; to = 1'b0; acc = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         rdy = in_ready;
         @(negedge clk);
         if (rdy) begin
            acc = cyc;
            break;
         end
         n++;
         if (n > 5000) begin
            to = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic rx_frame(input int div, output logic [10:0] fr,
                           output int fall, output bit to);
      int n;
      n = 0; to = 1'b0; fr = '0; fall = 0;
      while (tx !== 1'b0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) begin
         to = 1'b1;
         return;
      end
      fall = cyc;
      for (int k = 0; k < FB; k++) begin
         while (cyc < fall + k*div + div/2) @(negedge clk);
         fr[k] = tx;
      end
   endtask

   task automatic cfg_write(input logic [31:0] v);
      cfg_div_we = 1'b1;
      cfg_div_di = v;
      @(negedge clk);
      cfg_div_we = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      vec++;
      if (busy !== 1'b0) begin
         err++;
         $display("FAIL idle_wait: got busy=%b want 0", busy);
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      int edges;
      logic prev;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      vec++;
      if (tx !== 1'b1) begin
         err++; $display("FAIL reset_tx: got %b want 1", tx);
      end
      vec++;
      if (in_ready !== 1'b1) begin
         err++; $display("FAIL reset_ready: got %b want 1", in_ready);
      end
      vec++;
      if (level !== 5'd0) begin
         err++; $display("FAIL reset_level: got %0d want 0", level);
      end
      vec++;
      if (busy !== 1'b0) begin
         err++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      vec++;
      if (cfg_div_do !== 32'd106) begin
         err++; $display("FAIL reset_div: got %0d want 106", cfg_div_do);
      end
      edges = 0;
      prev = tx;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== prev) edges++;
         prev = tx;
      end
      vec++;
      if (edges !== 0) begin
         err++; $display("FAIL reset_quiet: got %0d edges want 0", edges);
      end
   endtask

   task automatic test_single();
      int acc, fall;
      bit to;
      logic [10:0] fr;
      push(8'h55, acc, to);
      vec++;
      if (to) begin
         err++; $display("FAIL single_push: got timeout want accept");
      end
      vec++;
      if (level !== 5'd1) begin
         err++; $display("FAIL single_level: got %0d want 1", level);
      end
      rx_frame(DIV, fr, fall, to);
      vec++;
      if (to) begin
         err++; $display("FAIL single_rx: got timeout want frame");
      end
      vec++;
      if (fall !== acc + 1) begin
         err++; $display("FAIL single_latency: got %0d want %0d", fall, acc + 1);
      end
      vec++;
      if (fr !== exp_frame(8'h55)) begin
         err++; $display("FAIL single_frame: got %b want %b", fr, exp_frame(8'h55));
      end
      vec++;
      if (fr[8:1] !== 8'h55) begin
         err++; $display("FAIL single_char: got %h want 55", fr[8:1]);
      end
      while (cyc < fall + FB*DIV - 1) @(negedge clk);
      vec++;
      if (busy !== 1'b1) begin
         err++; $display("FAIL single_busy_hold: got %b want 1", busy);
      end
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         err++; $display("FAIL single_busy_drop: got busy=%b tx=%b want 0 1", busy, tx);
      end
   endtask

   task automatic test_fill();
      int acc [18];
      int fall [18];
      logic [10:0] fr [18];
      bit pto, rto;
      pto = 1'b0; rto = 1'b0;
      fork
         begin
            for (int i = 0; i < 18; i++) begin
               bit t;
               push(8'(i), acc[i], t);
               if (t) pto = 1'b1;
               if (i == 16) begin
                  vec++;
                  if (level !== 5'd16 || in_ready !== 1'b0) begin
                     err++;
                     $display("FAIL fill_full: got level=%0d ready=%b want 16 0", level, in_ready);
                  end
               end
            end
         end
         begin
            for (int i = 0; i < 18; i++) begin
               bit t;
               rx_frame(DIV, fr[i], fall[i], t);
               if (t) rto = 1'b1;
            end
         end
      join
      vec++;
      if (pto || rto) begin
         err++; $display("FAIL fill_timeout: got push=%b rx=%b want 0 0", pto, rto);
      end
      for (int i = 0; i < 18; i++) begin
         vec++;
         if (fr[i] !== exp_frame(8'(i))) begin
            err++; $display("FAIL fill_data%0d: got %b want %b", i, fr[i], exp_frame(8'(i)));
         end
      end
      vec++;
      if (fall[0] !== acc[0] + 1) begin
         err++; $display("FAIL fill_start: got %0d want %0d", fall[0], acc[0] + 1);
      end
      for (int i = 1; i < 18; i++) begin
         vec++;
         if (fall[i] - fall[i-1] !== FB*DIV) begin
            err++; $display("FAIL fill_gap%0d: got %0d want %0d", i, fall[i] - fall[i-1], FB*DIV);
         end
      end
      vec++;
      if (acc[17] !== fall[1] + 1) begin
         err++; $display("FAIL fill_stall: got %0d want %0d", acc[17], fall[1] + 1);
      end
      wait_idle();
   endtask

   task automatic test_div_change();
      int a0, a1, f1, f2;
      bit t0, t1, t2, t3;
      logic [10:0] fr1, fr2;
      push(8'h41, a0, t0);
      push(8'h42, a1, t1);
      fork
         rx_frame(DIV, fr1, f1, t2);
         begin
            repeat (300) @(negedge clk);
            cfg_write(32'h20);
            vec++;
            if (cfg_div_do !== 32'd32) begin
               err++; $display("FAIL div_readback: got %0d want 32", cfg_div_do);
            end
         end
      join
      rx_frame(32, fr2, f2, t3);
      vec++;
      if (t0 || t1 || t2 || t3) begin
         err++; $display("FAIL div_timeout: got %b%b%b%b want 0000", t0, t1, t2, t3);
      end
      vec++;
      if (fr1 !== exp_frame(8'h41)) begin
         err++; $display("FAIL div_frame1: got %b want %b", fr1, exp_frame(8'h41));
      end
      vec++;
      if (f2 - f1 !== FB*DIV) begin
         err++; $display("FAIL div_len1: got %0d want %0d", f2 - f1, FB*DIV);
      end
      vec++;
      if (fr2 !== exp_frame(8'h42)) begin
         err++; $display("FAIL div_frame2: got %b want %b", fr2, exp_frame(8'h42));
      end
      while (cyc < f2 + FB*32 - 1) @(negedge clk);
      vec++;
      if (busy !== 1'b1) begin
         err++; $display("FAIL div_len2_hold: got %b want 1", busy);
      end
      @(negedge clk);
      vec++;
      if (busy !== 1'b0) begin
         err++; $display("FAIL div_len2_end: got %b want 0", busy);
      end
      cfg_write(32'd1);
      vec++;
      if (cfg_div_do !== 32'd2) begin
         err++; $display("FAIL div_clamp: got %0d want 2", cfg_div_do);
      end
      cfg_write(32'd106);
      vec++;
      if (cfg_div_do !== 32'd106) begin
         err++; $display("FAIL div_restore: got %0d want 106", cfg_div_do);
      end
   endtask

   task automatic test_reset_mid();
      int acc, fall, n, lows;
      bit t, tx_to;
      logic [10:0] fr;
      wait_idle();
      push(8'hA5, acc, t);
      push(8'h11, acc, t);
      push(8'h22, acc, t);
      push(8'h33, acc, t);
      n = 0;
      while (tx !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      fall = cyc;
      vec++;
      if (level !== 5'd3 || tx !== 1'b0) begin
         err++; $display("FAIL rmid_queued: got level=%0d tx=%b want 3 0", level, tx);
      end
      while (cyc < fall + 4*DIV + 50) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vec++;
      if (tx !== 1'b1 || level !== 5'd0 || busy !== 1'b0) begin
         err++; $display("FAIL rmid_after: got tx=%b level=%0d busy=%b want 1 0 0", tx, level, busy);
      end
      lows = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      vec++;
      if (lows !== 0) begin
         err++; $display("FAIL rmid_silent: got %0d low cycles want 0", lows);
      end
      push(8'h3C, acc, t);
      rx_frame(DIV, fr, fall, tx_to);
      vec++;
      if (t || tx_to || fr !== exp_frame(8'h3C)) begin
         err++; $display("FAIL rmid_next: got %b want %b", fr, exp_frame(8'h3C));
      end
      wait_idle();
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      int a, f1, f2;
      bit t0, t1, t2, t3;
      logic [10:0] fr1, fr2;
      push(8'h07, a, t0);
      push(8'h03, a, t1);
      rx_frame(DIV, fr1, f1, t2);
      rx_frame(DIV, fr2, f2, t3);
      vec++;
      if (t0 || t1 || t2 || t3) begin
         err++; $display("FAIL par_timeout: got %b%b%b%b want 0000", t0, t1, t2, t3);
      end
      vec++;
      if (fr1 !== 11'b11000001110) begin
         err++; $display("FAIL par_frame07: got %b want 11000001110", fr1);
      end
      vec++;
      if (fr2 !== 11'b10000000110) begin
         err++; $display("FAIL par_frame03: got %b want 10000000110", fr2);
      end
      vec++;
      if (f2 - f1 !== 11*DIV) begin
         err++; $display("FAIL par_len: got %0d want %0d", f2 - f1, 11*DIV);
      end
      wait_idle();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_div_change();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
